// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and constants for the multicycle control sequencer.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_TRAP    = 3'd5,
    ST_WFI     = 3'd6
  } ctrl_state_e;

  // Next-PC select; PLUS_4 is encoded as zero so an idle sequencer selects it.
  typedef enum logic [2:0] {
    PC_PLUS_4 = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_MTVEC  = 3'd3,
    PC_MEPC   = 3'd4
  } pc_source_e;

  localparam logic [31:0] CAUSE_FETCH_FAULT = 32'd1;
  localparam logic [31:0] CAUSE_ILLEGAL     = 32'd2;
  localparam logic [31:0] CAUSE_LOAD_FAULT  = 32'd5;
  localparam logic [31:0] CAUSE_STORE_FAULT = 32'd7;
  localparam logic [31:0] CAUSE_M_TIMER_IRQ = {1'b1, 31'd7};

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Wait-cycle counter for an outstanding memory request with timeout flag.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic start,
  input  logic run,
  input  logic done,
  output logic timeout
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Clear on start; otherwise count request cycles that ended without completion.
  always_ff @(posedge clk) begin
    if (start) begin
      count <= '0;
    end else if (run && !done && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // The current request cycle is the last one allowed before a fault.
  assign timeout = run && (count == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle core control sequencer: fetch/decode/execute/mem/writeback with traps and WFI.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_branch,
  input  logic        is_jump,
  input  logic        reg_write,
  input  logic        branch_taken,
  input  logic        illegal,
  input  logic        exc_request,
  input  logic        exc_ret,
  input  logic        is_wfi,
  input  logic [31:0] exc_cause,
  input  logic        irq_pending,
  input  logic        mem_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output pc_source_e  pc_source,
  output logic        trap_we,
  output logic [31:0] trap_cause,
  output logic        mret_o,
  output logic        retire
);

  ctrl_state_e state, state_nxt;
  logic [31:0] cause_q, cause_nxt;
  logic        cause_ld;
  logic        br_taken_q;
  logic        req_now, req_nxt;
  logic        tmr_start, tmr_timeout;

  assign req_now   = (state == ST_FETCH) || (state == ST_MEM);
  assign req_nxt   = (state_nxt == ST_FETCH) || (state_nxt == ST_MEM);
  // Restart the wait count whenever a fresh request phase begins.
  assign tmr_start = rst || (req_nxt && !req_now);

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .start   (tmr_start),
    .run     (req_now),
    .done    (mem_done),
    .timeout (tmr_timeout)
  );

  // State register and latched trap cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_FETCH;
      cause_q <= '0;
    end else begin
      state <= state_nxt;
      if (cause_ld) begin
        cause_q <= cause_nxt;
      end
    end
  end

  // Capture the compare result as EXECUTE ends so WB sees the EXECUTE-cycle value.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_taken_q <= 1'b0;
    end else if (state == ST_EXECUTE) begin
      br_taken_q <= branch_taken;
    end
  end

  // Next-state and strobe decode; everything is held at zero while in reset.
  always_comb begin
    state_nxt    = state;
    cause_nxt    = cause_q;
    cause_ld     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    rf_we        = 1'b0;
    pc_source    = PC_PLUS_4;
    trap_we      = 1'b0;
    trap_cause   = '0;
    mret_o       = 1'b0;
    retire       = 1'b0;
    if (!rst) begin
      case (state)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (mem_done) begin
            ir_we     = 1'b1;
            state_nxt = ST_DECODE;
          end else if (tmr_timeout) begin
            state_nxt = ST_TRAP;
            cause_ld  = 1'b1;
            cause_nxt = CAUSE_FETCH_FAULT;
          end
        end
        ST_DECODE: begin
          if (illegal) begin
            state_nxt = ST_TRAP;
            cause_ld  = 1'b1;
            cause_nxt = CAUSE_ILLEGAL;
          end else if (exc_request) begin
            state_nxt = ST_TRAP;
            cause_ld  = 1'b1;
            cause_nxt = exc_cause;
          end else if (exc_ret) begin
            state_nxt = ST_WB;
          end else if (is_wfi) begin
            state_nxt = ST_WFI;
          end else begin
            state_nxt = ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          state_nxt = (is_load || is_store) ? ST_MEM : ST_WB;
        end
        ST_MEM: begin
          mem_req      = 1'b1;
          mem_we       = is_store;
          mem_addr_sel = 1'b1;
          if (mem_done) begin
            state_nxt = ST_WB;
          end else if (tmr_timeout) begin
            state_nxt = ST_TRAP;
            cause_ld  = 1'b1;
            cause_nxt = is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
          end
        end
        ST_WB: begin
          pc_we  = 1'b1;
          retire = 1'b1;
          rf_we  = reg_write && !is_store;
          mret_o = exc_ret;
          if (exc_ret) begin
            pc_source = PC_MEPC;
          end else if (is_jump) begin
            pc_source = PC_JUMP;
          end else if (is_branch && br_taken_q) begin
            pc_source = PC_BRANCH;
          end else begin
            pc_source = PC_PLUS_4;
          end
          if (irq_pending) begin
            state_nxt = ST_TRAP;
            cause_ld  = 1'b1;
            cause_nxt = CAUSE_M_TIMER_IRQ;
          end else begin
            state_nxt = ST_FETCH;
          end
        end
        ST_TRAP: begin
          trap_we    = 1'b1;
          pc_we      = 1'b1;
          pc_source  = PC_MTVEC;
          trap_cause = cause_q;
          state_nxt  = ST_FETCH;
        end
        ST_WFI: begin
          if (irq_pending) begin
            state_nxt = ST_WB;
          end
        end
        default: begin
          state_nxt = ST_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench: instruction-level reference model of the sequencer's cycle trace.
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        is_load, is_store, is_branch, is_jump, reg_write, branch_taken;
  logic        illegal, exc_request, exc_ret, is_wfi;
  logic [31:0] exc_cause;
  logic        irq_pending, mem_done;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
  pc_source_e  pc_source;
  logic        trap_we, mret_o, retire;
  logic [31:0] trap_cause;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic ld, st, br, jmp, rw, bt, ill, ecall, mret, wfi;
    logic [31:0] cause;
  } instr_t;

  multicycle_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .is_load      (is_load),
    .is_store     (is_store),
    .is_branch    (is_branch),
    .is_jump      (is_jump),
    .reg_write    (reg_write),
    .branch_taken (branch_taken),
    .illegal      (illegal),
    .exc_request  (exc_request),
    .exc_ret      (exc_ret),
    .is_wfi       (is_wfi),
    .exc_cause    (exc_cause),
    .irq_pending  (irq_pending),
    .mem_done     (mem_done),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .rf_we        (rf_we),
    .pc_source    (pc_source),
    .trap_we      (trap_we),
    .trap_cause   (trap_cause),
    .mret_o       (mret_o),
    .retire       (retire)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [43:0] vec(input logic req, we, sel, ir, pcw, rfw,
                                      input pc_source_e src, input logic tw, mr, ret,
                                      input logic [31:0] cause);
    return {req, we, sel, ir, pcw, rfw, src, tw, mr, ret, cause};
  endfunction

  // Compare all outputs mid-cycle, then advance to just after the next edge.
  task automatic step(input string tag, input logic [43:0] exp);
    logic [43:0] obs;
    @(negedge clk);
    obs = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we, pc_source,
           trap_we, mret_o, retire, trap_cause};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input instr_t ins);
    is_load     = ins.ld;
    is_store    = ins.st;
    is_branch   = ins.br;
    is_jump     = ins.jmp;
    reg_write   = ins.rw;
    illegal     = ins.ill;
    exc_request = ins.ecall;
    exc_ret     = ins.mret;
    is_wfi      = ins.wfi;
    exc_cause   = ins.cause;
  endtask

  task automatic trap(input string tag, input logic [31:0] cause);
    irq_pending  = 1'($urandom);
    mem_done     = 1'($urandom);
    branch_taken = 1'($urandom);
    step(tag, vec(0, 0, 0, 0, 1, 0, PC_MTVEC, 1, 0, 0, cause));
  endtask

  // Retire one instruction: fw/mw are wait cycles before mem_done in FETCH/MEM
  // (>= TMO means the access never completes), irq_wb is irq_pending during WB.
  task automatic run_instr(input instr_t ins, input int fw, input int mw,
                           input bit irq_wb, input int wfi_wait);
    bit got;
    pc_source_e src;
    rst = 1'b0;
    set_flags(ins);
    got = 1'b0;
    for (int i = 0; i < TMO && !got; i++) begin
      got          = (i == fw);
      mem_done     = got;
      irq_pending  = 1'($urandom);
      branch_taken = 1'($urandom);
      step("fetch", vec(1, 0, 0, got, 0, 0, PC_PLUS_4, 0, 0, 0, 32'd0));
    end
    if (!got) begin
      trap("fetch_fault_trap", CAUSE_FETCH_FAULT);
      return;
    end
    mem_done    = 1'($urandom);
    irq_pending = 1'b1;
    step("decode", '0);
    if (ins.ill || ins.ecall) begin
      trap("sync_trap", ins.ill ? CAUSE_ILLEGAL : ins.cause);
      return;
    end
    if (!ins.mret && ins.wfi) begin
      for (int i = 0; i < wfi_wait; i++) begin
        irq_pending = 1'b0;
        mem_done    = 1'($urandom);
        step("wfi_hold", '0);
      end
      irq_pending = 1'b1;
      step("wfi_wake", '0);
    end else if (!ins.mret) begin
      branch_taken = ins.bt;
      irq_pending  = 1'($urandom);
      mem_done     = 1'($urandom);
      step("execute", '0);
      if (ins.ld || ins.st) begin
        got = 1'b0;
        for (int i = 0; i < TMO && !got; i++) begin
          got          = (i == mw);
          mem_done     = got;
          irq_pending  = 1'($urandom);
          branch_taken = 1'($urandom);
          step("mem", vec(1, ins.st, 1, 0, 0, 0, PC_PLUS_4, 0, 0, 0, 32'd0));
        end
        if (!got) begin
          trap("mem_fault_trap", ins.st ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT);
          return;
        end
      end
    end
    src = ins.mret ? PC_MEPC : ins.jmp ? PC_JUMP :
          (ins.br && ins.bt) ? PC_BRANCH : PC_PLUS_4;
    branch_taken = ~ins.bt;
    irq_pending  = irq_wb;
    mem_done     = 1'($urandom);
    step("wb", vec(0, 0, 0, 0, 1, ins.rw && !ins.st, src, 0, ins.mret, 1, 32'd0));
    if (irq_wb) trap("irq_trap", CAUSE_M_TIMER_IRQ);
  endtask

  function automatic instr_t mk_instr(input int kind);
    instr_t r;
    r = '0;
    case (kind)
      0: r.rw = 1'b1;
      1: begin r.ld = 1'b1; r.rw = 1'($urandom); end
      2: begin r.st = 1'b1; r.rw = 1'($urandom); end
      3: begin r.br = 1'b1; r.bt = 1'($urandom); r.rw = 1'($urandom); end
      4: begin r.jmp = 1'b1; r.rw = 1'b1; end
      5: begin r.ill = 1'b1; r.ecall = 1'($urandom); r.cause = {1'b0, 31'($urandom)}; end
      6: begin r.ecall = 1'b1; r.cause = 32'($urandom_range(0, 15)); end
      7: r.mret = 1'b1;
      default: r.wfi = 1'b1;
    endcase
    return r;
  endfunction

  initial begin
    instr_t ins;
    rst = 1'b1;
    set_flags('0);
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_done    = 1'b1;
      irq_pending = 1'($urandom);
      illegal     = 1'($urandom);
      step("reset_outputs_zero", '0);
    end

    // ALU op, fetch completes two cycles after the request
    run_instr(mk_instr(0), 2, 0, 1'b0, 0);
    // load with zero-wait fetch and data access
    run_instr(mk_instr(1), 0, 0, 1'b0, 0);
    // store whose data access never completes
    ins = mk_instr(2); ins.rw = 1'b1;
    run_instr(ins, 1, TMO + 10, 1'b0, 0);
    // load completing in the very last allowed cycle
    run_instr(mk_instr(1), 0, TMO - 1, 1'b0, 0);
    // fetch that never completes
    run_instr(mk_instr(0), TMO + 10, 0, 1'b0, 0);
    // ECALL with interrupt pending in DECODE, then interrupt at next WB
    ins = mk_instr(6); ins.cause = 32'd11;
    run_instr(ins, 0, 0, 1'b0, 0);
    run_instr(mk_instr(0), 1, 0, 1'b1, 0);
    // WFI woken after ten cycles
    run_instr(mk_instr(8), 0, 0, 1'b1, 10);
    // taken branch, jump, mret, illegal-with-ecall
    ins = mk_instr(3); ins.bt = 1'b1;
    run_instr(ins, 1, 0, 1'b0, 0);
    run_instr(mk_instr(4), 0, 0, 1'b0, 0);
    run_instr(mk_instr(7), 0, 0, 1'b0, 0);
    ins = mk_instr(5); ins.ecall = 1'b1; ins.cause = 32'd11;
    run_instr(ins, 0, 0, 1'b0, 0);

    // reset in the second cycle of a data access
    ins = mk_instr(1);
    set_flags(ins);
    rst = 1'b0; irq_pending = 1'b0; mem_done = 1'b1;
    step("rst_fetch", vec(1, 0, 0, 1, 0, 0, PC_PLUS_4, 0, 0, 0, 32'd0));
    mem_done = 1'b0;
    step("rst_decode", '0);
    step("rst_execute", '0);
    step("rst_mem1", vec(1, 0, 1, 0, 0, 0, PC_PLUS_4, 0, 0, 0, 32'd0));
    rst = 1'b1;
    step("rst_in_mem", '0);
    mem_done = 1'b1;
    step("rst_late_done", '0);
    run_instr(mk_instr(0), 1, 0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      int kind;
      kind = $urandom_range(0, 8);
      run_instr(mk_instr(kind), $urandom_range(0, 4), $urandom_range(0, 4),
                ($urandom_range(0, 3) == 0) || (kind == 8), $urandom_range(0, 5));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
